sb_commit_drainer: RTL and testbench
====================================

# sb_commit_drainer

Commit-side drain engine for the data-cache store buffer. It consumes the oldest store-buffer entry through the buffer's sender handshake once the matching store has retired. It probes the cache tag port and writes hits into the data SRAM write port. Misses and uncached stores are forwarded as single-beat bus writes, since the cache is write-no-allocate. It sits between the commit stage, the `storebuffer` sender interface and port 1 of the dcache tag/data SRAMs.

## Interface
- WAY_NUM, 2, cache ways
- SB_SIZE, 4, store-buffer depth; credit counter is $clog2(SB_SIZE)+1 bits
- DATA_DEPTH, 256, sets; index = paddr[11:TAG_ADDR_LOW], TAG_ADDR_LOW = 12-$clog2(DATA_DEPTH)
- WORD_ADDR_W, 10, data SRAM word index width, paddr[11:2]
---
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-high (port name kept as used across the codebase)
- retire_i  in  2  number of stores retired this cycle (0..2)
- sb_valid_i  in  1  store-buffer head valid
- sb_ready_o  out  1  pop head (handshake ready)
- sb_paddr_i  in  32  head physical address
- sb_wdata_i  in  32  head store data
- sb_strb_i  in  4  head byte strobe
- sb_uncached_i  in  1  head is uncached
- tag_en_o  out  1  tag port-1 read enable
- tag_addr_o  out  $clog2(DATA_DEPTH)  tag read index
- tag_rdata_i  in  WAY_NUM*22  {tag[19:0],v,d} per way, valid cycle after tag_en_o
- dwe_o  out  WAY_NUM  data port-1 way write enable (one-hot or zero)
- daddr_o  out  WORD_ADDR_W  data write word index
- dwdata_o  out  32  data write value
- dstrb_o  out  4  data byte write enable
- bus_valid_o  out  1  bus write request
- bus_ready_i  in  1  bus accepts request
- bus_addr_o / bus_data_o / bus_strb_o  out  32/32/4  request payload
- bus_ack_i  in  1  write completion pulse
- idle_o  out  1  no drain in flight and credit==0

## Operation
- Credit counter: +retire_i every cycle; −1 on each pop (sb_valid_i&&sb_ready_o). Both in the same cycle apply together. Saturates at SB_SIZE; retire while saturated is a protocol error and is flagged only by assertion.
- States: IDLE, LOOKUP, WRITE, BUS_REQ, BUS_WAIT.
- IDLE: sb_ready_o = sb_valid_i && credit!=0. On pop, latch the head into a holding register. Cached entries assert tag_en_o with tag_addr_o = index and go to LOOKUP. Uncached entries go to BUS_REQ.
- LOOKUP: hit[i] = v && tag==latched paddr[31:12]. Any hit goes to WRITE with way = lowest hit index. No hit goes to BUS_REQ.
- WRITE: dwe_o=one-hot way, daddr_o=paddr[11:2], dwdata_o/dstrb_o from the latch; go to IDLE. Dirty-bit update is not driven here.
- BUS_REQ: bus_valid_o=1 with the payload held stable until bus_ready_i; then go to BUS_WAIT. bus_valid_o never drops before acceptance.
- BUS_WAIT: wait for bus_ack_i, then go to IDLE. An ack arriving in any other state is ignored.
- flush_i is not a port. Retired stores always drain; uncommitted entries are removed by the store buffer itself.
- Reset: state IDLE, credit 0, latch 0. All outputs 0 except idle_o=1.

## Timing
- Cached hit: pop at cycle 0 (tag_en_o), compare at cycle 1, SRAM write at cycle 2. Next pop is possible at cycle 3.
- Miss: pop at 0, LOOKUP at 1, bus_valid_o from cycle 2. Next pop is possible the cycle after bus_ack_i.
- Uncached: bus_valid_o in the cycle after the pop.
- sb_ready_o is combinational from sb_valid_i and registered credit/state only; it never depends on bus or tag inputs.
- Reset asserted mid-drain aborts immediately: bus_valid_o and dwe_o drop asynchronously, and the in-flight store is lost.

## Configuration
- SB_DRAIN_FASTHIT_EN:
  - Defined: the LOOKUP hit performs the data write in the same cycle (WRITE state is skipped). Another pop is allowed in that same LOOKUP cycle when credit and head are available, which re-arms LOOKUP. Hit throughput is 1 store per cycle after the first.
  - Undefined: the WRITE state is used as specified, giving 1 store per 3 cycles.

## Test plan
- Reset, then retire_i=1 with head {paddr=0x0000_1234, data=0xDEADBEEF, strb=0xF}, way1 tag 0x00001 valid -> tag_addr_o=0x23 at pop; dwe_o=2'b10, daddr_o=0x08D, dstrb_o=0xF two cycles later.
- Head valid with credit=0 for 10 cycles -> sb_ready_o stays 0. Then retire_i=2 -> two pops, credit returns to 0, idle_o=1 after the final write.
- Miss at 0x8000_0040 with bus_ready_i low for 5 cycles -> bus_valid_o held with stable addr/data/strb. Pop only resumes after bus_ack_i.
- Uncached store strb=0x3 -> no tag_en_o; bus request with bus_strb_o=0x3 in the cycle after the pop.
- Same-cycle retire_i=1 and pop at credit=1 -> credit stays 1. Both ways hit (tag alias) -> way0 written.
- Reset asserted while in BUS_REQ -> bus_valid_o=0 immediately, credit=0. With SB_DRAIN_FASTHIT_EN defined, 4 back-to-back hits complete in 5 cycles.

Source files
------------

// File: rtl/sb_commit_drainer.sv
// Drains retired stores from the store-buffer head into dcache port 1 (hit) or a single-beat bus write (miss/uncached).
// Latency: hit pop->SRAM write 2 cycles (1 with SB_DRAIN_FASTHIT_EN defined); miss/uncached bus_valid_o 2/1 cycles after pop.
// Backpressure: pops only with retire credit in IDLE; bus request held stable until bus_ready_i, next pop after bus_ack_i.
module sb_commit_drainer #(
    parameter int WAY_NUM     = 2,
    parameter int SB_SIZE     = 4,
    parameter int DATA_DEPTH  = 256,
    parameter int WORD_ADDR_W = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    retire_i,
    input  logic                          sb_valid_i,
    output logic                          sb_ready_o,
    input  logic [31:0]                   sb_paddr_i,
    input  logic [31:0]                   sb_wdata_i,
    input  logic [3:0]                    sb_strb_i,
    input  logic                          sb_uncached_i,
    output logic                          tag_en_o,
    output logic [$clog2(DATA_DEPTH)-1:0] tag_addr_o,
    input  logic [WAY_NUM*22-1:0]         tag_rdata_i,
    output logic [WAY_NUM-1:0]            dwe_o,
    output logic [WORD_ADDR_W-1:0]        daddr_o,
    output logic [31:0]                   dwdata_o,
    output logic [3:0]                    dstrb_o,
    output logic                          bus_valid_o,
    input  logic                          bus_ready_i,
    output logic [31:0]                   bus_addr_o,
    output logic [31:0]                   bus_data_o,
    output logic [3:0]                    bus_strb_o,
    input  logic                          bus_ack_i,
    output logic                          idle_o
);

    localparam int IDX_W        = $clog2(DATA_DEPTH);
    localparam int TAG_ADDR_LOW = 12 - IDX_W;
    localparam int CRED_W       = $clog2(SB_SIZE) + 1;
    localparam logic [CRED_W:0] SB_MAX = (CRED_W+1)'(SB_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITE,
        S_BUS_REQ,
        S_BUS_WAIT
    } state_t;

    // One store-buffer entry as held while it drains (uncached flag is consumed at pop time).
    typedef struct packed {
        logic [31:0] paddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } sb_ent_t;

    state_t               state, state_nxt;
    sb_ent_t              hold, head;
    logic [WAY_NUM-1:0]   way_q;
    logic [CRED_W-1:0]    credit;
    logic [CRED_W:0]      credit_sum;
    logic                 credit_nz;
    logic                 can_pop;
    logic                 pop;
    logic                 hold_ld;
    logic                 way_ld;
    logic [WAY_NUM-1:0]   hit;
    logic [WAY_NUM-1:0]   hit_oh;
    logic [WAY_NUM-1:0]   unused_dirty;

`ifdef SB_DRAIN_FASTHIT_EN
    // A head popped in the same LOOKUP cycle as a miss parks here until the bus write completes.
    sb_ent_t              pend;
    logic                 pend_unc;
    logic                 pend_vld;
    logic                 pend_ld;
    logic                 pend_to_hold;
`endif

    assign head       = '{paddr: sb_paddr_i, wdata: sb_wdata_i, strb: sb_strb_i};
    assign credit_nz  = |credit;
    // Ready depends only on the head valid and registered credit/state, never on tag or bus inputs.
    assign can_pop    = sb_valid_i && credit_nz;
    assign pop        = sb_valid_i && sb_ready_o;
    // Pop can only happen with credit!=0, so the subtraction never underflows.
    assign credit_sum = {1'b0, credit}
                      + {{(CRED_W-1){1'b0}}, retire_i}
                      - {{CRED_W{1'b0}}, pop};

`ifdef SB_DRAIN_FASTHIT_EN
    assign idle_o = (state == S_IDLE) && !credit_nz && !pend_vld;
`else
    assign idle_o = (state == S_IDLE) && !credit_nz;
`endif

    // Per-way hit against the latched address; the lowest hit way wins on a tag alias.
    always_comb begin
        hit          = '0;
        unused_dirty = '0;
        for (int i = 0; i < WAY_NUM; i++) begin
            hit[i]          = tag_rdata_i[i*22+1] && (tag_rdata_i[i*22+2 +: 20] == hold.paddr[31:12]);
            unused_dirty[i] = tag_rdata_i[i*22];
        end
        hit_oh = hit & (~hit + WAY_NUM'(1));
    end

    // Next-state and all handshake/SRAM/bus outputs.
    always_comb begin
        state_nxt   = state;
        sb_ready_o  = 1'b0;
        tag_en_o    = 1'b0;
        tag_addr_o  = '0;
        dwe_o       = '0;
        daddr_o     = '0;
        dwdata_o    = '0;
        dstrb_o     = '0;
        bus_valid_o = 1'b0;
        bus_addr_o  = '0;
        bus_data_o  = '0;
        bus_strb_o  = '0;
        hold_ld     = 1'b0;
        way_ld      = 1'b0;
`ifdef SB_DRAIN_FASTHIT_EN
        pend_ld      = 1'b0;
        pend_to_hold = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                sb_ready_o = can_pop;
                if (can_pop) begin
                    hold_ld = 1'b1;
                    if (sb_uncached_i) begin
                        state_nxt = S_BUS_REQ;
                    end else begin
                        tag_en_o   = 1'b1;
                        tag_addr_o = sb_paddr_i[11:TAG_ADDR_LOW];
                        state_nxt  = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
`ifdef SB_DRAIN_FASTHIT_EN
                // Write the hit immediately and overlap the next pop with it.
                sb_ready_o = can_pop;
                if (|hit) begin
                    dwe_o    = hit_oh;
                    daddr_o  = hold.paddr[WORD_ADDR_W+1:2];
                    dwdata_o = hold.wdata;
                    dstrb_o  = hold.strb;
                    if (can_pop) begin
                        hold_ld = 1'b1;
                        if (sb_uncached_i) begin
                            state_nxt = S_BUS_REQ;
                        end else begin
                            tag_en_o   = 1'b1;
                            tag_addr_o = sb_paddr_i[11:TAG_ADDR_LOW];
                            state_nxt  = S_LOOKUP;
                        end
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    pend_ld   = can_pop;
                    state_nxt = S_BUS_REQ;
                end
`else
                if (|hit) begin
                    way_ld    = 1'b1;
                    state_nxt = S_WRITE;
                end else begin
                    state_nxt = S_BUS_REQ;
                end
`endif
            end
            S_WRITE: begin
                dwe_o     = way_q;
                daddr_o   = hold.paddr[WORD_ADDR_W+1:2];
                dwdata_o  = hold.wdata;
                dstrb_o   = hold.strb;
                state_nxt = S_IDLE;
            end
            S_BUS_REQ: begin
                bus_valid_o = 1'b1;
                bus_addr_o  = hold.paddr;
                bus_data_o  = hold.wdata;
                bus_strb_o  = hold.strb;
                if (bus_ready_i) begin
                    state_nxt = S_BUS_WAIT;
                end
            end
            S_BUS_WAIT: begin
                if (bus_ack_i) begin
                    state_nxt = S_IDLE;
`ifdef SB_DRAIN_FASTHIT_EN
                    if (pend_vld) begin
                        pend_to_hold = 1'b1;
                        if (pend_unc) begin
                            state_nxt = S_BUS_REQ;
                        end else begin
                            tag_en_o   = 1'b1;
                            tag_addr_o = pend.paddr[11:TAG_ADDR_LOW];
                            state_nxt  = S_LOOKUP;
                        end
                    end
`endif
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; reset aborts any in-flight drain.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Retire credit: retires and pops in the same cycle net out, saturating at SB_SIZE.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            credit <= '0;
        end else if (credit_sum > SB_MAX) begin
            credit <= SB_MAX[CRED_W-1:0];
        end else begin
            credit <= credit_sum[CRED_W-1:0];
        end
    end

    // Holding register for the entry being drained plus the selected hit way.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            hold  <= '0;
            way_q <= '0;
        end else begin
            if (hold_ld) begin
                hold <= head;
            end
`ifdef SB_DRAIN_FASTHIT_EN
            else if (pend_to_hold) begin
                hold <= pend;
            end
`endif
            if (way_ld) begin
                way_q <= hit_oh;
            end
        end
    end

`ifdef SB_DRAIN_FASTHIT_EN
    // Parking slot for a head popped alongside a LOOKUP miss.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pend     <= '0;
            pend_unc <= 1'b0;
            pend_vld <= 1'b0;
        end else if (pend_ld) begin
            pend     <= head;
            pend_unc <= sb_uncached_i;
            pend_vld <= 1'b1;
        end else if (pend_to_hold) begin
            pend_vld <= 1'b0;
        end
    end
`endif

    // Retiring more stores than the buffer can hold is a commit-side protocol error.
    a_credit_overflow: assert property (@(posedge clk) disable iff (rst_n) credit_sum <= SB_MAX);

endmodule

// File: tb/tb_sb_commit_drainer.sv
module tb_sb_commit_drainer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  retire_i = '0;
    logic        sb_valid_i = 1'b0;
    logic        sb_ready_o;
    logic [31:0] sb_paddr_i = '0;
    logic [31:0] sb_wdata_i = '0;
    logic [3:0]  sb_strb_i = '0;
    logic        sb_uncached_i = 1'b0;
    logic        tag_en_o;
    logic [7:0]  tag_addr_o;
    logic [43:0] tag_rdata_i = '0;
    logic [1:0]  dwe_o;
    logic [9:0]  daddr_o;
    logic [31:0] dwdata_o;
    logic [3:0]  dstrb_o;
    logic        bus_valid_o;
    logic        bus_ready_i = 1'b0;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [3:0]  bus_strb_o;
    logic        bus_ack_i = 1'b0;
    logic        idle_o;

    int checks = 0;
    int errors = 0;

    sb_commit_drainer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .retire_i      (retire_i),
        .sb_valid_i    (sb_valid_i),
        .sb_ready_o    (sb_ready_o),
        .sb_paddr_i    (sb_paddr_i),
        .sb_wdata_i    (sb_wdata_i),
        .sb_strb_i     (sb_strb_i),
        .sb_uncached_i (sb_uncached_i),
        .tag_en_o      (tag_en_o),
        .tag_addr_o    (tag_addr_o),
        .tag_rdata_i   (tag_rdata_i),
        .dwe_o         (dwe_o),
        .daddr_o       (daddr_o),
        .dwdata_o      (dwdata_o),
        .dstrb_o       (dstrb_o),
        .bus_valid_o   (bus_valid_o),
        .bus_ready_i   (bus_ready_i),
        .bus_addr_o    (bus_addr_o),
        .bus_data_o    (bus_data_o),
        .bus_strb_o    (bus_strb_o),
        .bus_ack_i     (bus_ack_i),
        .idle_o        (idle_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_head(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic u);
        sb_paddr_i    = a;
        sb_wdata_i    = d;
        sb_strb_i     = s;
        sb_uncached_i = u;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] exp_daddr [4];
        int k, w, cyc, first_pop, last_wr, span_exp;
        logic popped;

        // ---------------- reset state ----------------
        #2;
        chk("rst_idle", idle_o, 1);
        chk("rst_ready", sb_ready_o, 0);
        chk("rst_bus_valid", bus_valid_o, 0);
        chk("rst_dwe", dwe_o, 0);
        chk("rst_tag_en", tag_en_o, 0);
        tick();
        rst_n = 1'b0;

        // ---------------- cached hit in way1 ----------------
        tag_rdata_i = {20'h00001, 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0};
        set_head(32'h0000_1234, 32'hDEAD_BEEF, 4'hF, 1'b0);
        sb_valid_i = 1'b1;
        retire_i   = 2'd1;
        #1 chk("hit_ready_nocredit", sb_ready_o, 0);
        tick();
        retire_i = 2'd0;
        #1;
        chk("hit_ready", sb_ready_o, 1);
        chk("hit_tag_en", tag_en_o, 1);
        chk("hit_tag_addr", tag_addr_o, 8'h23);
        tick();
        sb_valid_i = 1'b0;
        #1 chk("hit_lookup_dwe", dwe_o, 0);
        tick();
        #1;
        chk("hit_dwe", dwe_o, 2'b10);
        chk("hit_daddr", daddr_o, 10'h08D);
        chk("hit_dwdata", dwdata_o, 32'hDEAD_BEEF);
        chk("hit_dstrb", dstrb_o, 4'hF);
        tick();
        #1 chk("hit_idle_after", idle_o, 1);

        // ---------------- no credit for 10 cycles, then retire 2 ----------------
        set_head(32'h0000_1238, 32'h0000_0001, 4'hF, 1'b0);
        sb_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1 chk("nocredit_ready", sb_ready_o, 0);
            tick();
        end
        retire_i = 2'd2;
        #1 chk("retire2_ready_same_cycle", sb_ready_o, 0);
        tick();
        retire_i = 2'd0;
        #1;
        chk("retire2_credit", dut.credit, 2);
        chk("retire2_pop1", sb_ready_o, 1);
        tick();
        set_head(32'h0000_123C, 32'h0000_0002, 4'hF, 1'b0);
        #1 chk("retire2_credit_after_pop1", dut.credit, 1);
        tick();
        #1;
        chk("retire2_dwe1", dwe_o, 2'b10);
        chk("retire2_daddr1", daddr_o, 10'h08E);
        tick();
        #1 chk("retire2_pop2", sb_ready_o, 1);
        tick();
        sb_valid_i = 1'b0;
        tick();
        #1;
        chk("retire2_daddr2", daddr_o, 10'h08F);
        chk("retire2_not_idle_in_write", idle_o, 0);
        tick();
        #1;
        chk("retire2_idle", idle_o, 1);
        chk("retire2_credit_zero", dut.credit, 0);

        // ---------------- miss with bus backpressure ----------------
        set_head(32'h8000_0040, 32'h0BAD_F00D, 4'hC, 1'b0);
        sb_valid_i = 1'b1;
        retire_i   = 2'd1;
        tick();
        retire_i = 2'd0;
        #1;
        chk("miss_tag_en", tag_en_o, 1);
        chk("miss_tag_addr", tag_addr_o, 8'h04);
        tick();
        retire_i = 2'd1;
        set_head(32'h4000_0010, 32'h1122_3344, 4'h3, 1'b1);
        #1 chk("miss_lookup_ready", sb_ready_o, 0);
        tick();
        retire_i = 2'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("miss_bus_valid_held", bus_valid_o, 1);
            chk("miss_bus_addr", bus_addr_o, 32'h8000_0040);
            chk("miss_bus_data", bus_data_o, 32'h0BAD_F00D);
            chk("miss_bus_strb", bus_strb_o, 4'hC);
            chk("miss_ready_blocked", sb_ready_o, 0);
            tick();
        end
        bus_ready_i = 1'b1;
        #1 chk("miss_bus_valid_accept", bus_valid_o, 1);
        tick();
        bus_ready_i = 1'b0;
        #1;
        chk("miss_wait_bus_valid", bus_valid_o, 0);
        chk("miss_wait_ready", sb_ready_o, 0);
        tick();
        bus_ack_i = 1'b1;
        #1 chk("miss_ack_cycle_ready", sb_ready_o, 0);
        tick();
        bus_ack_i = 1'b0;

        // ---------------- uncached store ----------------
        #1;
        chk("unc_ready", sb_ready_o, 1);
        chk("unc_no_tag_en", tag_en_o, 0);
        tick();
        sb_valid_i  = 1'b0;
        bus_ready_i = 1'b1;
        #1;
        chk("unc_bus_valid", bus_valid_o, 1);
        chk("unc_bus_strb", bus_strb_o, 4'h3);
        chk("unc_bus_addr", bus_addr_o, 32'h4000_0010);
        chk("unc_bus_data", bus_data_o, 32'h1122_3344);
        tick();
        bus_ready_i = 1'b0;
        bus_ack_i   = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        #1 chk("unc_idle", idle_o, 1);
        // Stray ack while idle is ignored.
        bus_ack_i = 1'b1;
        tick();
        bus_ack_i = 1'b0;
        #1;
        chk("stray_ack_idle", idle_o, 1);
        chk("stray_ack_bus_valid", bus_valid_o, 0);

        // ---------------- same-cycle retire+pop, tag alias ----------------
        tag_rdata_i = {20'h00001, 1'b1, 1'b0, 20'h00001, 1'b1, 1'b1};
        set_head(32'h0000_1230, 32'hCAFE_F00D, 4'h5, 1'b0);
        retire_i = 2'd1;
        tick();
        sb_valid_i = 1'b1;
        #1 chk("alias_ready", sb_ready_o, 1);
        tick();
        retire_i   = 2'd0;
        sb_valid_i = 1'b0;
        #1 chk("alias_credit_stays", dut.credit, 1);
        tick();
        #1;
        chk("alias_dwe_way0", dwe_o, 2'b01);
        chk("alias_daddr", daddr_o, 10'h08C);
        chk("alias_dwdata", dwdata_o, 32'hCAFE_F00D);
        chk("alias_dstrb", dstrb_o, 4'h5);
        tick();
        #1 chk("alias_not_idle_credit", idle_o, 0);

        // ---------------- reset during BUS_REQ ----------------
        set_head(32'h8000_0080, 32'h5555_AAAA, 4'hF, 1'b0);
        sb_valid_i = 1'b1;
        tick();
        sb_valid_i = 1'b0;
        retire_i   = 2'd1;
        tick();
        retire_i = 2'd0;
        #1;
        chk("rstmid_bus_valid_before", bus_valid_o, 1);
        chk("rstmid_credit_before", dut.credit, 1);
        rst_n = 1'b1;
        #1;
        chk("rstmid_bus_valid_async", bus_valid_o, 0);
        chk("rstmid_dwe", dwe_o, 0);
        chk("rstmid_credit", dut.credit, 0);
        chk("rstmid_idle", idle_o, 1);
        tick();
        rst_n = 1'b0;

        // ---------------- four back-to-back hits ----------------
        exp_daddr[0] = 10'h08C;
        exp_daddr[1] = 10'h08D;
        exp_daddr[2] = 10'h08E;
        exp_daddr[3] = 10'h08F;
        retire_i = 2'd2;
        tick();
        tick();
        retire_i = 2'd0;
        #1 chk("b2b_credit_full", dut.credit, 4);
        k = 0; w = 0; cyc = 0; first_pop = -1; last_wr = -1;
        while (w < 4 && cyc < 40) begin
            sb_valid_i = (k < 4);
            set_head(32'h0000_1230 + 32'(k*4), 32'h1000_0000 + 32'(k), 4'hF, 1'b0);
            #1;
            popped = sb_valid_i && sb_ready_o;
            if (popped && first_pop < 0) first_pop = cyc;
            if (dwe_o != 2'b00) begin
                chk("b2b_daddr", daddr_o, exp_daddr[w]);
                chk("b2b_dwdata", dwdata_o, 32'h1000_0000 + 32'(w));
                w++;
                last_wr = cyc;
            end
            tick();
            if (popped) k++;
            cyc++;
        end
        sb_valid_i = 1'b0;
`ifdef SB_DRAIN_FASTHIT_EN
        span_exp = 5;
`else
        span_exp = 12;
`endif
        chk("b2b_writes", w, 4);
        chk("b2b_span", last_wr - first_pop + 1, span_exp);
        tick();
        #1;
        chk("b2b_credit_end", dut.credit, 0);
        chk("b2b_idle_end", idle_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
